// File: rtl/move_input_conditioner_if.sv
// Move command handshake between the input conditioner (master) and the game FSM (slave).
//   move_valid : a move is pending (master -> slave)
//   move_dir   : 00 right, 01 up, 10 down, 11 left; stable while move_valid (master -> slave)
//   move_ready : slave accepts the pending move this cycle (slave -> master)
interface move_input_conditioner_if;
  logic       move_valid;
  logic       move_ready;
  logic [1:0] move_dir;

  modport master (
    output move_valid,
    output move_dir,
    input  move_ready
  );

  modport slave (
    input  move_valid,
    input  move_dir,
    output move_ready
  );
endinterface

// File: rtl/move_input_conditioner.sv
// Front end of the 2048 game: turns four raw active-low push buttons into clean,
// one-per-press move commands.
// Per button: 2-flop synchronizer, counter debouncer, press-edge detector. A small FSM
// holds one pending move until accepted, counts presses dropped while pending, then
// blocks new moves until every button is released.
// Optional build macro AUTO_REPEAT_EN: while a single button matching the last move stays
// held, a new move of the same direction is issued every REPEAT_CYCLES cycles.
// Ports:
//   clk_i           system clock, rising edge
//   rst_ni          synchronous reset, active-low
//   buttons_i       raw buttons, active-low; [3] left, [2] down, [1] up, [0] right
//   move_if         master side of the move handshake (valid/dir out, ready in)
//   buttons_clean_o debounced levels, active-high
//   drop_count_o    presses discarded while a move was pending, saturating at 255
module move_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned REPEAT_CYCLES   = 1000000
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [3:0]                     buttons_i,
  move_input_conditioner_if.master       move_if,
  output logic [3:0]                     buttons_clean_o,
  output logic [7:0]                     drop_count_o
);

  localparam logic [CNT_W-1:0] DebMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Elaboration-time parameter sanity checks.
  if (DEBOUNCE_CYCLES < 2) begin : g_chk_deb
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (REPEAT_CYCLES == 0) begin : g_chk_rep
    $error("REPEAT_CYCLES must be non-zero");
  end

  typedef enum logic [1:0] {StIdle, StPending, StWaitRelease} state_e;

  logic [3:0]       sync1_q, sync2_q;
  logic [3:0]       clean_q, clean_d, clean_dly_q;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [3:0]       rise;
  logic [1:0]       prio_dir;

  state_e     state_q;
  logic       valid_q;
  logic [1:0] dir_q;
  logic [7:0] drop_q;

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RepMax = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] rep_q;
`endif

  // Debounce: a level change is taken only after DEBOUNCE_CYCLES consecutive differing
  // samples; any agreeing sample restarts the count.
  always_comb begin
    clean_d = clean_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != clean_q[i]) begin
        if (cnt_q[i] == DebMax) begin
          clean_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign rise = clean_q & ~clean_dly_q;

  // Simultaneous presses: left > down > up > right.
  always_comb begin
    prio_dir = 2'd0;
    if (rise[3])      prio_dir = 2'd3;
    else if (rise[2]) prio_dir = 2'd2;
    else if (rise[1]) prio_dir = 2'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      clean_q     <= '0;
      clean_dly_q <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q     <= ~buttons_i;
      sync2_q     <= sync1_q;
      clean_q     <= clean_d;
      clean_dly_q <= clean_q;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      valid_q <= 1'b0;
      dir_q   <= 2'd0;
      drop_q  <= 8'd0;
`ifdef AUTO_REPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (|rise) begin
            dir_q   <= prio_dir;
            valid_q <= 1'b1;
            state_q <= StPending;
          end
        end
        StPending: begin
          // A press seen in the accept cycle is still a drop.
          if (|rise && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
          if (move_if.move_ready) begin
            valid_q <= 1'b0;
            state_q <= StWaitRelease;
          end
        end
        StWaitRelease: begin
`ifdef AUTO_REPEAT_EN
          if (clean_q == 4'd0) begin
            rep_q   <= '0;
            state_q <= StIdle;
          end else if (clean_q != clean_dly_q || clean_q != (4'd1 << dir_q)) begin
            rep_q <= '0;
          end else if (rep_q == RepMax) begin
            rep_q   <= '0;
            valid_q <= 1'b1;
            state_q <= StPending;
          end else begin
            rep_q <= rep_q + 1'b1;
          end
`else
          if (clean_q == 4'd0) state_q <= StIdle;
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign move_if.move_valid = valid_q;
  assign move_if.move_dir   = dir_q;
  assign buttons_clean_o    = clean_q;
  assign drop_count_o       = drop_q;

endmodule

// File: tb/tb_move_input_conditioner.sv
module tb_move_input_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] buttons;
  logic [3:0] clean;
  logic [7:0] drop;

  always #5 clk = ~clk;

  move_input_conditioner_if mif ();

  move_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (20),
    .REPEAT_CYCLES  (8)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .buttons_i      (buttons),
    .move_if        (mif),
    .buttons_clean_o(clean),
    .drop_count_o   (drop)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  logic [1:0] exp_q[$];
  logic       prev_valid = 1'b0;
  logic [1:0] mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every newly presented move is checked against the scoreboard queue.
  always @(negedge clk) begin
    if (mif.move_valid === 1'b1 && !prev_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_move: got dir %0d, required no move", mif.move_dir);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("move_dir", {30'd0, mif.move_dir}, {30'd0, mon_exp});
      end
    end
    prev_valid = (mif.move_valid === 1'b1);
  end

  initial begin
    rst_n          = 1'b0;
    buttons        = 4'hF;
    mif.move_ready = 1'b0;
    wait_n(3);
    chk("rst_valid", mif.move_valid, 0);
    chk("rst_dir", mif.move_dir, 0);
    chk("rst_clean", clean, 0);
    chk("rst_drop", drop, 0);
    rst_n = 1'b1;

    // Single press, latency and handshake.
    buttons = 4'b1110;
    exp_q.push_back(2'd0);
    wait_n(5);
    chk("clean_early", clean, 0);
    wait_n(1);
    chk("clean_latency", clean, 4'b0001);
    chk("valid_early", mif.move_valid, 0);
    wait_n(1);
    chk("valid_latency", mif.move_valid, 1);
    chk("dir_right", mif.move_dir, 0);
    mif.move_ready = 1'b1;
    wait_n(1);
    chk("valid_after_ready", mif.move_valid, 0);
    mif.move_ready = 1'b0;
    buttons = 4'hF;
    wait_n(10);
    chk("clean_released", clean, 0);

    // Bounce on down: 3 low / 1 high, five times, then steady low.
    mif.move_ready = 1'b1;
    exp_q.push_back(2'd2);
    repeat (5) begin
      buttons = 4'b1011;
      wait_n(3);
      buttons = 4'b1111;
      wait_n(1);
    end
    chk("bounce_clean", clean, 0);
    chk("bounce_no_early", exp_q.size(), 1);
    buttons = 4'b1011;
    wait_n(6);
    chk("bounce_steady_clean", clean, 4'b0100);
    wait_n(4);
    chk("bounce_one_move", exp_q.size(), 0);
    buttons = 4'hF;
    wait_n(10);

    // Simultaneous left+up+right.
    exp_q.push_back(2'd3);
    buttons = 4'b0100;
    wait_n(12);
    chk("simul_clean", clean, 4'b1011);
    chk("simul_drop", drop, 0);
    chk("simul_one_move", exp_q.size(), 0);
    buttons = 4'hF;
    wait_n(10);
    mif.move_ready = 1'b0;

    // Backpressure: up pending, two down presses dropped.
    exp_q.push_back(2'd1);
    buttons = 4'b1101;
    wait_n(10);
    chk("bp_valid", mif.move_valid, 1);
    chk("bp_dir", mif.move_dir, 1);
    buttons = 4'hF;
    wait_n(10);
    repeat (2) begin
      buttons = 4'b1011;
      wait_n(10);
      buttons = 4'hF;
      wait_n(10);
    end
    chk("bp_drop", drop, 2);
    chk("bp_valid_held", mif.move_valid, 1);
    chk("bp_dir_held", mif.move_dir, 1);
    mif.move_ready = 1'b1;
    wait_n(1);
    chk("bp_accept", mif.move_valid, 0);
    wait_n(20);
    chk("bp_no_down_move", mif.move_valid, 0);
    mif.move_ready = 1'b0;

    // Reset while up is pending and held.
    exp_q.push_back(2'd1);
    buttons = 4'b1101;
    wait_n(10);
    chk("mid_valid", mif.move_valid, 1);
    rst_n = 1'b0;
    wait_n(1);
    chk("mid_rst_valid", mif.move_valid, 0);
    chk("mid_rst_dir", mif.move_dir, 0);
    chk("mid_rst_clean", clean, 0);
    chk("mid_rst_drop", drop, 0);
    rst_n = 1'b1;
    exp_q.push_back(2'd1);
    wait_n(6);
    chk("post_rst_clean", clean, 4'b0010);
    chk("post_rst_valid_early", mif.move_valid, 0);
    wait_n(1);
    chk("post_rst_valid", mif.move_valid, 1);
    chk("post_rst_dir", mif.move_dir, 1);
    mif.move_ready = 1'b1;
    buttons = 4'hF;
    wait_n(10);

    // Hold left with immediate accept.
    exp_q.push_back(2'd3);
`ifdef AUTO_REPEAT_EN
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd3);
`endif
    buttons = 4'b0111;
    wait_n(27);
    buttons = 4'hF;
    wait_n(12);
    chk("hold_moves_done", exp_q.size(), 0);
    chk("hold_valid_idle", mif.move_valid, 0);
    mif.move_ready = 1'b0;
    wait_n(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
